golden_netlist_checker: RTL and testbench
=========================================

Name: golden_netlist_checker

Overview:
- Synthesizable downstream consumer of the golden and post-route netlist outputs of a design-under-test.
- Aligns the two 32-bit output streams through independent programmable delay lines.
- Samples them on a fixed compare cadence and counts mismatches.
- Captures the first failing sample and raises done/pass, replacing the bench-side compare task with on-chip checking for FPGA bring-up of post-route netlists.

Parameters:
- WIDTH, 32, data width of the golden and netlist buses.
- GOLD_DLY, 0, pipeline stages applied to golden (0..7).
- NET_DLY, 0, pipeline stages applied to netlist (0..7).
- SETTLE_CYC, 2, cycles waited after start before the first compare (1..255).
- SAMPLE_EVERY, 2, compare period in cycles (1..15).
- NUM_CHECKS, 1000, number of compares per run (1..2^CNT_W-1).
- CNT_W, 16, width of the counters and index outputs.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run when in IDLE or DONE, ignored otherwise.
- golden  in  WIDTH  golden model output.
- netlist  in  WIDTH  post-route netlist output; bit order matches golden.
- busy  out  1  high in SETTLE or RUN.
- done  out  1  high in DONE.
- pass  out  1  valid while done; 1 iff mismatch_cnt==0.
- mismatch_cnt  out  CNT_W  saturating count of failed compares.
- check_cnt  out  CNT_W  compares performed this run.
- first_bad_valid  out  1  a mismatch has been captured this run.
- first_bad_idx  out  CNT_W  check_cnt value (0-based) of the first mismatch.
- first_bad_golden  out  WIDTH  aligned golden word at the first mismatch.
- first_bad_netlist  out  WIDTH  aligned netlist word at the first mismatch.

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; all outputs 0; delay-line registers 0; phase and settle counters 0.
- Delay lines:
  - golden_a is golden delayed GOLD_DLY cycles; netlist_a is netlist delayed NET_DLY cycles.
  - A delay of 0 is a combinational pass-through.
  - Delay lines shift every cycle regardless of state.
- FSM:
  - IDLE: on start, clear mismatch_cnt, check_cnt, first_bad_*, pass; load settle counter with SETTLE_CYC; go to SETTLE.
  - SETTLE: decrement each cycle; on reaching 0, go to RUN with phase counter=0.
  - RUN: the phase counter counts 0..SAMPLE_EVERY-1 and wraps.
    - A compare occurs on cycles where phase==SAMPLE_EVERY-1, so the first compare is SAMPLE_EVERY cycles after entering RUN.
    - On compare: check_cnt++.
    - If golden_a!=netlist_a (any bit differs): mismatch_cnt++ (holds at 2^CNT_W-1).
    - If it is the first mismatch of the run: latch first_bad_idx=old check_cnt, first_bad_golden=golden_a, first_bad_netlist=netlist_a, first_bad_valid=1. Later mismatches do not overwrite these.
    - When the compare that makes check_cnt==NUM_CHECKS completes, go to DONE.
  - DONE: done=1; pass=(mismatch_cnt==0), registered on DONE entry. Results hold until the next start, which behaves as from IDLE (same cycle clears, done drops).
- busy=1 exactly in SETTLE and RUN; done and busy are never both 1.
- start while busy is ignored; no restart mid-run.
- Reset asserted mid-run aborts immediately to IDLE with all outputs 0; deassertion requires a new start.
- Registered outputs; the counter update is visible the cycle after the compare edge.
- Equality is a full-width bitwise compare; there is no masking.

Test Plan:
- Matching streams: golden=netlist=pseudo-random, defaults, pulse start → done after 2+2*1000=2002 cycles (±1 for the start edge); pass=1, mismatch_cnt=0, check_cnt=1000, first_bad_valid=0.
- Single corruption: netlist bit 31 flipped only on compare #37 → mismatch_cnt=1, pass=0, first_bad_idx=37, first_bad_golden/netlist differ only in bit 31.
- Alignment: NET_DLY=3, GOLD_DLY=0, netlist source driven 3 cycles early relative to golden → pass=1. With NET_DLY=0 and the same stimulus → mismatch_cnt=1000.
- Saturation: CNT_W=4, NUM_CHECKS=15, netlist=~golden → mismatch_cnt=15; with NUM_CHECKS=15 and CNT_W=4 the count holds at 15, with no wrap to 0.
- Control: start pulsed while busy → ignored, check_cnt continues. Reset asserted at compare #500 → all outputs 0 within the same cycle. New start → fresh run ends with check_cnt=1000.
- Restart from DONE with a failed previous run: start → first_bad_valid=0, mismatch_cnt=0 on the next cycle, busy=1.

Source files
------------

// File: rtl/golden_netlist_checker.sv
// golden_netlist_checker: on-chip compare of golden vs post-route netlist
// output streams. Each stream goes through its own programmable delay line.
// The aligned words are compared on a fixed cadence. The block counts
// mismatches and captures the first failing sample of each run.
module golden_netlist_checker #(
    parameter int WIDTH        = 32,
    parameter int GOLD_DLY     = 0,
    parameter int NET_DLY      = 0,
    parameter int SETTLE_CYC   = 2,
    parameter int SAMPLE_EVERY = 2,
    parameter int NUM_CHECKS   = 1000,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] netlist,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] check_cnt,
    output logic             first_bad_valid,
    output logic [CNT_W-1:0] first_bad_idx,
    output logic [WIDTH-1:0] first_bad_golden,
    output logic [WIDTH-1:0] first_bad_netlist
);

    typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_t;

    localparam logic [7:0]       SETTLE_LD = 8'(SETTLE_CYC);
    localparam logic [3:0]       PH_LAST   = 4'(SAMPLE_EVERY - 1);
    localparam logic [CNT_W-1:0] NUM_C     = CNT_W'(NUM_CHECKS);

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    logic [WIDTH-1:0] golden_a, netlist_a;
    state_t           state, state_nxt;
    logic [7:0]       settle_cnt;
    logic [3:0]       phase;
    logic             clr, cmp, last, mism;
    logic [CNT_W-1:0] check_inc;

    // ---- stage p0: alignment delay lines (free-running, independent of FSM)
    generate
        if (GOLD_DLY == 0) begin : g_gold_thru
            assign golden_a = golden;
        end else begin : g_gold_dly
            logic [WIDTH-1:0] gold_p [GOLD_DLY];
            // Shift golden through GOLD_DLY register stages.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < GOLD_DLY; i++) gold_p[i] <= '0;
                end else begin
                    gold_p[0] <= golden;
                    for (int i = 1; i < GOLD_DLY; i++) gold_p[i] <= gold_p[i-1];
                end
            end
            assign golden_a = gold_p[GOLD_DLY-1];
        end

        if (NET_DLY == 0) begin : g_net_thru
            assign netlist_a = netlist;
        end else begin : g_net_dly
            logic [WIDTH-1:0] net_p [NET_DLY];
            // Shift netlist through NET_DLY register stages.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < NET_DLY; i++) net_p[i] <= '0;
                end else begin
                    net_p[0] <= netlist;
                    for (int i = 1; i < NET_DLY; i++) net_p[i] <= net_p[i-1];
                end
            end
            assign netlist_a = net_p[NET_DLY-1];
        end
    endgenerate

    // ---- stage p1: sequencing and compare
    assign mism      = (golden_a != netlist_a);
    assign check_inc = check_cnt + 1'b1;
    assign busy      = (state == SETTLE) || (state == RUN);
    assign done      = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state plus one-cycle strobes for clear, compare and final compare.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        cmp       = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = SETTLE;
                    clr       = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_cnt <= 8'd1) state_nxt = RUN;
            end
            RUN: begin
                if (phase == PH_LAST) begin
                    cmp = 1'b1;
                    if (check_inc == NUM_C) begin
                        last      = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Settle countdown and compare-phase counter. The phase counter is
    // held at 0 outside RUN, so each run starts its cadence from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle_cnt <= '0;
            phase      <= '0;
        end else begin
            if (clr)                  settle_cnt <= SETTLE_LD;
            else if (state == SETTLE) settle_cnt <= settle_cnt - 1'b1;

            if (state != RUN)         phase <= '0;
            else if (phase == PH_LAST) phase <= '0;
            else                      phase <= phase + 1'b1;
        end
    end

    // ---- stage p2: result registers
    // Clear on start. On a compare, update the counters and latch the first
    // mismatch. On the final compare, register the verdict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass              <= 1'b0;
            mismatch_cnt      <= '0;
            check_cnt         <= '0;
            first_bad_valid   <= 1'b0;
            first_bad_idx     <= '0;
            first_bad_golden  <= '0;
            first_bad_netlist <= '0;
        end else if (clr) begin
            pass              <= 1'b0;
            mismatch_cnt      <= '0;
            check_cnt         <= '0;
            first_bad_valid   <= 1'b0;
            first_bad_idx     <= '0;
            first_bad_golden  <= '0;
            first_bad_netlist <= '0;
        end else if (cmp) begin
            check_cnt <= check_inc;
            if (mism) begin
                mismatch_cnt <= sat_inc(mismatch_cnt);
                if (!first_bad_valid) begin
                    first_bad_valid   <= 1'b1;
                    first_bad_idx     <= check_cnt;
                    first_bad_golden  <= golden_a;
                    first_bad_netlist <= netlist_a;
                end
            end
            if (last) pass <= (mismatch_cnt == '0) && !mism;
        end
    end

endmodule

// File: tb/tb_golden_netlist_checker.sv
// Directed bench for golden_netlist_checker: clean run, alignment,
// saturation, single corruption, restart, ignored start and mid-run reset.
module tb_golden_netlist_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, start_d;
    logic [31:0] gold_a, net_a, gold_b, net_b, gold_d, net_d;

    logic        busy_a, done_a, pass_a, fbv_a;
    logic [15:0] mm_a, cc_a, idx_a;
    logic [31:0] fbg_a, fbn_a;
    logic        busy_b, done_b, pass_b, fbv_b;
    logic [15:0] mm_b, cc_b, idx_b;
    logic [31:0] fbg_b, fbn_b;
    logic        busy_c, done_c, pass_c, fbv_c;
    logic [15:0] mm_c, cc_c, idx_c;
    logic [31:0] fbg_c, fbn_c;
    logic        busy_d, done_d, pass_d, fbv_d;
    logic [3:0]  mm_d, cc_d, idx_d;
    logic [31:0] fbg_d, fbn_d;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    int corrupt_e = -1;

    always #5 clk = ~clk;

    // Instance A: defaults.
    golden_netlist_checker u_a (
        .clk(clk), .rst(rst), .start(start_a), .golden(gold_a), .netlist(net_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch_cnt(mm_a),
        .check_cnt(cc_a), .first_bad_valid(fbv_a), .first_bad_idx(idx_a),
        .first_bad_golden(fbg_a), .first_bad_netlist(fbn_a));

    // Instance B: netlist delayed 3 to align an early netlist stream.
    golden_netlist_checker #(.NET_DLY(3)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .golden(gold_b), .netlist(net_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch_cnt(mm_b),
        .check_cnt(cc_b), .first_bad_valid(fbv_b), .first_bad_idx(idx_b),
        .first_bad_golden(fbg_b), .first_bad_netlist(fbn_b));

    // Instance C: same stimulus as B, no alignment delay.
    golden_netlist_checker u_c (
        .clk(clk), .rst(rst), .start(start_b), .golden(gold_b), .netlist(net_b),
        .busy(busy_c), .done(done_c), .pass(pass_c), .mismatch_cnt(mm_c),
        .check_cnt(cc_c), .first_bad_valid(fbv_c), .first_bad_idx(idx_c),
        .first_bad_golden(fbg_c), .first_bad_netlist(fbn_c));

    // Instance D: narrow counters, every compare fails.
    golden_netlist_checker #(.CNT_W(4), .NUM_CHECKS(15)) u_d (
        .clk(clk), .rst(rst), .start(start_d), .golden(gold_d), .netlist(net_d),
        .busy(busy_d), .done(done_d), .pass(pass_d), .mismatch_cnt(mm_d),
        .check_cnt(cc_d), .first_bad_valid(fbv_d), .first_bad_idx(idx_d),
        .first_bad_golden(fbg_d), .first_bad_netlist(fbn_d));

    function automatic logic [31:0] f(input int e);
        return 32'(e) * 32'h9E37_79B1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive the words that the next rising edge (n+1) will sample.
    task automatic drive();
        int e;
        e      = n + 1;
        gold_a = f(e);
        net_a  = (e == corrupt_e) ? (f(e) ^ 32'h8000_0000) : f(e);
        gold_b = f(e);
        net_b  = f(e + 3);
        gold_d = f(e);
        net_d  = ~f(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        drive();
    endtask

    task automatic wait_done(input int budget, output int k);
        k = 0;
        while (!done_a && k < budget) begin
            step();
            k++;
        end
        chk("done_timeout", done_a, 1);
    endtask

    initial begin
        int k;
        int ce;
        rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_d = 1'b0;
        drive();
        repeat (3) step();

        // Reset state
        chk("rst_ctl", {busy_a, done_a, pass_a, fbv_a}, 4'b0000);
        chk("rst_cnt", {mm_a, cc_a, idx_a}, 48'd0);
        chk("rst_fb", {fbg_a, fbn_a}, 64'd0);
        chk("rst_d", {busy_d, done_d, mm_d, cc_d}, 10'd0);

        rst = 1'b1;
        step();

        // Run 1: A clean, B aligned, C misaligned, D saturating
        start_a = 1'b1; start_b = 1'b1; start_d = 1'b1;
        step();
        start_a = 1'b0; start_b = 1'b0; start_d = 1'b0;
        chk("r1_busy", {busy_a, done_a}, 2'b10);
        wait_done(2100, k);
        chk("r1_latency", k, 2002);
        chk("r1_a_ctl", {busy_a, pass_a, fbv_a}, 3'b010);
        chk("r1_a_mm", mm_a, 0);
        chk("r1_a_cc", cc_a, 1000);
        chk("r1_b_pass", {done_b, pass_b, fbv_b}, 3'b110);
        chk("r1_b_mm", mm_b, 0);
        chk("r1_c_mm", mm_c, 1000);
        chk("r1_c_ctl", {done_c, pass_c, fbv_c}, 3'b101);
        chk("r1_c_idx", idx_c, 0);
        chk("r1_d_mm", mm_d, 15);
        chk("r1_d_cc", cc_d, 15);
        chk("r1_d_ctl", {done_d, busy_d, pass_d}, 3'b100);

        // Run 2: flip bit 31 of netlist on compare #37 only
        ce = n + 1 + 4 + 2 * 37;
        corrupt_e = ce;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_done(2100, k);
        chk("r2_mm", mm_a, 1);
        chk("r2_ctl", {done_a, pass_a, fbv_a}, 3'b101);
        chk("r2_idx", idx_a, 37);
        chk("r2_gold", fbg_a, f(ce));
        chk("r2_diff", fbg_a ^ fbn_a, 32'h8000_0000);
        chk("r2_cc", cc_a, 1000);

        // Run 3: restart from a failed DONE clears results at once
        corrupt_e = -1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("r3_clear", {fbv_a, busy_a, done_a, pass_a}, 4'b0100);
        chk("r3_mm", mm_a, 0);

        // Start while busy is ignored: 24 compares done by 50 edges after start
        repeat (49) step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("r3_ign_busy", busy_a, 1);
        chk("r3_ign_cc", cc_a, 24);

        // Reset at compare #500 zeroes everything immediately
        k = 0;
        while (cc_a != 16'd500 && k < 1200) begin
            step();
            k++;
        end
        chk("r3_cc500", cc_a, 500);
        rst = 1'b0;
        #1;
        chk("r3_rst_ctl", {busy_a, done_a, pass_a, fbv_a}, 4'b0000);
        chk("r3_rst_cnt", {mm_a, cc_a, idx_a}, 48'd0);
        rst = 1'b1;
        step();
        step();
        chk("r3_idle", {busy_a, done_a}, 2'b00);

        // Run 4: fresh run after reset
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_done(2100, k);
        chk("r4_cc", cc_a, 1000);
        chk("r4_pass", {pass_a, mm_a}, {1'b1, 16'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
